mdu_alu: RTL and testbench
==========================

MDU_ALU -- requirements
Module: mdu_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand width; legal values are powers of two, 4..64.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands and mode are valid this cycle.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 mode  input  3  operation: 0 MULU, 1 DIVU, 2 AND, 3 AVG, 4 OR, 5 XOR, 6-7 illegal.
REQ-007 in_A  input  WIDTH  first operand, unsigned; dividend for DIVU.
REQ-008 in_B  input  WIDTH  second operand, unsigned; divisor for DIVU.
REQ-009 out_valid  output  1  result, err and dz are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out  output  2*WIDTH  result.
REQ-012 err  output  1  the request carried an illegal mode.
REQ-013 dz  output  1  a DIVU request had divisor zero.

Function
REQ-014 A request is accepted on a rising edge where in_valid and in_ready are both high; in_A, in_B and mode are captured on that edge and are not sampled again.
REQ-015 in_ready is high only in IDLE; in_valid in any other state has no effect.
REQ-016 States are IDLE, MUL, DIV, LOGIC and DONE; the state register resets to IDLE.
REQ-017 IDLE transitions on acceptance: MULU to MUL, DIVU with nonzero in_B to DIV, all other modes to LOGIC; without acceptance IDLE holds.
REQ-018 MUL and DIV each last exactly WIDTH cycles, counted by a $clog2(WIDTH)-bit counter that clears on entry; on the terminal count the state goes to DONE.
REQ-019 LOGIC lasts 1 cycle, then goes to DONE.
REQ-020 DONE asserts out_valid and holds out, err and dz stable while out_ready is low; DONE goes to IDLE on a rising edge with out_ready high.
REQ-021 Latency: accept edge at cycle T gives out_valid first high in cycle T+1+WIDTH for MULU/DIVU and T+2 for all other modes; a DIVU with zero divisor takes the LOGIC path (T+2).
REQ-022 MULU: shift-add, one partial product per cycle; out = in_A*in_B, full 2*WIDTH bits; the carry out of each add is retained.
REQ-023 DIVU: restoring division using a WIDTH+1-bit trial subtract per cycle; out[2W-1:W] = remainder, out[W-1:0] = quotient.
REQ-024 DIVU with in_B=0: out = {in_A, all-ones}, dz=1.
REQ-025 AND/OR/XOR: out[W-1:0] = bitwise result; out[2W-1:W] = 0.
REQ-026 AVG: out[W-1:0] = (in_A+in_B)>>1, computed with a WIDTH+1-bit sum so no overflow; out[2W-1:W] = 0.
REQ-027 Illegal mode (6-7): out = 0, err=1, via LOGIC.
REQ-028 When out_valid is low: out = 0, err = 0, dz = 0.
REQ-029 err and dz are both low for every legal, nonzero-divisor request.
REQ-030 out_ready is ignored when out_valid is low.

Reset
REQ-031 While rst is high at a clock edge: the state goes to IDLE, the counter and datapath registers clear, and outputs go to in_ready=1, out_valid=0, out=0, err=0, dz=0.
REQ-032 rst asserted during MUL, DIV, LOGIC or DONE aborts the operation with no result; the first cycle after rst deasserts is IDLE with in_ready=1.
REQ-033 rst has priority over acceptance in the same cycle.

Structure
REQ-034 Package mdu_alu_pkg holds the mode encoding constants, the state enumeration and the illegal-mode range.
REQ-035 One sub-module, mdu_alu_addsub: a WIDTH+1-bit adder/subtractor with carry/borrow out, shared by MUL, DIV and AVG.
REQ-036 The datapath is a single 2*WIDTH shift register plus a WIDTH-bit operand register; there is no separate multiplier or divider array.

Verification
REQ-037 WIDTH=32, MULU, A=B=0xFFFFFFFF -> out=0xFFFFFFFE00000001, out_valid first high exactly 33 cycles after the accept edge.
REQ-038 WIDTH=32, DIVU, A=100, B=7 -> out=0x000000020000000E, dz=0; then A=5, B=0 -> out=0x00000005FFFFFFFF, dz=1, latency 2.
REQ-039 WIDTH=32, AVG, A=0xFFFFFFFF, B=1 -> out=0x0000000080000000; AND 0xF0F0F0F0 & 0xFF00FF00 -> out=0xF000F000.
REQ-040 Backpressure: out_ready low 5 cycles while in_valid stays high -> out is stable, in_ready=0, and no second accept occurs until the cycle after out_ready=1.
REQ-041 rst pulsed at cycle 10 of a MULU -> out_valid never rises for that request; the next request (mode 6) -> err=1, out=0.
REQ-042 WIDTH=8, MULU, A=B=0xFF -> out=0xFE01 at latency 9; DIVU, A=0xFF, B=0x10 -> out=0x0F0F.

Source files
------------

// File: rtl/mdu_alu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide/logic unit.
package mdu_alu_pkg;

    localparam logic [2:0] MODE_MULU        = 3'd0;
    localparam logic [2:0] MODE_DIVU        = 3'd1;
    localparam logic [2:0] MODE_AND         = 3'd2;
    localparam logic [2:0] MODE_AVG         = 3'd3;
    localparam logic [2:0] MODE_OR          = 3'd4;
    localparam logic [2:0] MODE_XOR         = 3'd5;
    localparam logic [2:0] MODE_ILLEGAL_MIN = 3'd6;
    localparam logic [2:0] MODE_ILLEGAL_MAX = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_LOGIC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mdu_alu_addsub.sv
// WIDTH+1-bit adder/subtractor; cout is the carry out, or "no borrow" when subtracting.
module mdu_alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           cout
);

    logic [WIDTH+1:0] full;

    assign full = {1'b0, a} + {1'b0, b ^ {(WIDTH+1){sub}}} + {{(WIDTH+1){1'b0}}, sub};
    assign sum  = full[WIDTH:0];
    assign cout = full[WIDTH+1];

endmodule

// File: rtl/mdu_alu.sv
// Multi-cycle unsigned ALU: shift-add multiply, restoring divide, single-cycle logic/average.
module mdu_alu
    import mdu_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 err,
    output logic                 dz
);

    localparam int CW = $clog2(WIDTH);

    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;
    logic [2:0]           mode_r;
    logic                 err_r, dz_r;
    logic                 last_step;

    logic [WIDTH:0]       as_a, as_b, as_sum;
    logic                 as_sub, as_cout;
    logic [WIDTH:0]       mul_hi;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   logic_res;
    logic                 logic_err, logic_dz;

    assign last_step = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (mode == MODE_MULU)
                        state_nx = ST_MUL;
                    else if (mode == MODE_DIVU && in_B != '0)
                        state_nx = ST_DIV;
                    else
                        state_nx = ST_LOGIC;
                end
            end
            ST_MUL, ST_DIV: if (last_step) state_nx = ST_DONE;
            ST_LOGIC:       state_nx = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default:        state_nx = ST_IDLE;
        endcase
    end

    // One shared adder: MUL adds into the high half, DIV trial-subtracts the shifted remainder.
    always_comb begin
        as_a   = {1'b0, acc[WIDTH-1:0]};
        as_b   = {1'b0, opb};
        as_sub = 1'b0;
        case (state)
            ST_MUL: as_a = {1'b0, acc[2*WIDTH-1:WIDTH]};
            ST_DIV: begin
                as_a   = acc[2*WIDTH-1:WIDTH-1];
                as_sub = 1'b1;
            end
            default: ;
        endcase
    end

    mdu_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    assign mul_hi  = acc[0]  ? as_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign div_rem = as_cout ? as_sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1];

    always_comb begin
        logic_res = '0;
        logic_err = 1'b0;
        logic_dz  = 1'b0;
        case (mode_r)
            MODE_AND: logic_res[WIDTH-1:0] = acc[WIDTH-1:0] & opb;
            MODE_OR:  logic_res[WIDTH-1:0] = acc[WIDTH-1:0] | opb;
            MODE_XOR: logic_res[WIDTH-1:0] = acc[WIDTH-1:0] ^ opb;
            MODE_AVG: logic_res[WIDTH-1:0] = as_sum[WIDTH:1];
            MODE_DIVU: begin
                logic_res = {acc[WIDTH-1:0], {WIDTH{1'b1}}};
                logic_dz  = 1'b1;
            end
            MODE_ILLEGAL_MIN, MODE_ILLEGAL_MAX: logic_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Capture at accept, then iterate one bit per cycle in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            mode_r <= '0;
            err_r  <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    acc    <= {{WIDTH{1'b0}}, in_A};
                    opb    <= in_B;
                    mode_r <= mode;
                    cnt    <= '0;
                    err_r  <= 1'b0;
                    dz_r   <= 1'b0;
                end
                ST_MUL: begin
                    acc <= {mul_hi, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                ST_DIV: begin
                    acc <= {div_rem, acc[WIDTH-2:0], as_cout};
                    cnt <= cnt + 1'b1;
                end
                ST_LOGIC: begin
                    acc   <= logic_res;
                    err_r <= logic_err;
                    dz_r  <= logic_dz;
                end
                default: ;
            endcase
        end
    end

    assign out = out_valid ? acc : '0;
    assign err = out_valid & err_r;
    assign dz  = out_valid & dz_r;

endmodule

// File: tb/tb_mdu_alu.sv
// Bench for mdu_alu: directed vectors, random ops against an arithmetic model, control corner cases.
module tb_mdu_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, err, dz;
    logic [2:0]  mode;
    logic [31:0] in_A, in_B;
    logic [63:0] out;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, err8, dz8;
    logic [2:0]  mode8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in_A(in_A), .in_B(in_B), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .err(err), .dz(dz)
    );

    mdu_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .mode(mode8),
        .in_A(a8), .in_B(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .err(err8), .dz(dz8)
    );

    typedef struct {
        logic [63:0] o;
        logic        e;
        logic        d;
        int          lat;
    } res_t;

    typedef struct {
        logic [2:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] o;
        logic        e;
        logic        d;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands; latency counted as in the cycle numbering of the interface.
    function automatic res_t model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic [32:0] s;
        r.o = '0; r.e = 1'b0; r.d = 1'b0; r.lat = 2;
        case (m)
            3'd0: begin r.o = 64'(a) * 64'(b); r.lat = 33; end
            3'd1: if (b != 0) begin r.o = {a % b, a / b}; r.lat = 33; end
                  else begin r.o = {a, 32'hFFFF_FFFF}; r.d = 1'b1; end
            3'd2: r.o = {32'h0, a & b};
            3'd3: begin s = {1'b0, a} + {1'b0, b}; r.o = {32'h0, s[32:1]}; end
            3'd4: r.o = {32'h0, a | b};
            3'd5: r.o = {32'h0, a ^ b};
            default: r.e = 1'b1;
        endcase
        return r;
    endfunction

    task automatic do_op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b, output res_t r);
        int n;
        mode = m; in_A = a; in_B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            checks++; failures++;
            $display("FAIL op_timeout mode=%0d actual=no_out_valid required=out_valid", m);
        end
        r.o = out; r.e = err; r.d = dz; r.lat = n + 1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic do_op8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] o, output int lat);
        int n;
        mode8 = m; a8 = a; b8 = b; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 100) begin @(posedge clk); #1; n++; end
        if (!out_valid8) begin
            checks++; failures++;
            $display("FAIL op8_timeout mode=%0d actual=no_out_valid required=out_valid", m);
        end
        o = out8; lat = n + 1;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        res_t r, x;
        logic [15:0] o8, e8;
        int lat8, seen;
        logic [7:0] ra8, rb8;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 33};
        vecs[1]  = '{3'd1, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0, 1'b0, 33};
        vecs[2]  = '{3'd1, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b0, 1'b1, 2};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_8000_0000, 1'b0, 1'b0, 2};
        vecs[4]  = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000, 1'b0, 1'b0, 2};
        vecs[5]  = '{3'd4, 32'h0F0F_0000, 32'h0000_00FF, 64'h0000_0000_0F0F_00FF, 1'b0, 1'b0, 2};
        vecs[6]  = '{3'd5, 32'hAAAA_AAAA, 32'hFFFF_0000, 64'h0000_0000_5555_AAAA, 1'b0, 1'b0, 2};
        vecs[7]  = '{3'd7, 32'd123,       32'd4,         64'h0,                   1'b1, 1'b0, 2};
        vecs[8]  = '{3'd0, 32'h1234_5678, 32'd0,         64'h0,                   1'b0, 1'b0, 33};
        vecs[9]  = '{3'd1, 32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[10] = '{3'd1, 32'd3,         32'hFFFF_FFFF, 64'h0000_0003_0000_0000, 1'b0, 1'b0, 33};
        vecs[11] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 33};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = '0; in_A = '0; in_B = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; mode8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_err", err, 0);
        chk("reset_dz", dz, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].m, vecs[i].a, vecs[i].b, r);
            chk($sformatf("vec%0d_out", i), r.o, vecs[i].o);
            chk($sformatf("vec%0d_err", i), r.e, vecs[i].e);
            chk($sformatf("vec%0d_dz", i), r.d, vecs[i].d);
            chk($sformatf("vec%0d_lat", i), r.lat, vecs[i].lat);
            chk($sformatf("vec%0d_idle_out", i), out, 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  m;
            logic [31:0] a, b;
            m = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            x = model(m, a, b);
            do_op(m, a, b, r);
            chk($sformatf("rnd%0d_m%0d_out", i, m), r.o, x.o);
            chk($sformatf("rnd%0d_m%0d_err", i, m), r.e, x.e);
            chk($sformatf("rnd%0d_m%0d_dz", i, m), r.d, x.d);
            chk($sformatf("rnd%0d_m%0d_lat", i, m), r.lat, x.lat);
        end

        // Backpressure with in_valid held high throughout.
        x = model(3'd2, 32'h1234_5678, 32'h0FF0_0FF0);
        mode = 3'd2; in_A = 32'h1234_5678; in_B = 32'h0FF0_0FF0; in_valid = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        while (!out_valid && seen < 10) begin @(posedge clk); #1; seen++; end
        chk("bp_first_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_out", k), out, x.o);
            chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
            chk($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_idle", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("bp_second_accept", in_ready, 0);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 10) begin @(posedge clk); #1; seen++; end
        chk("bp_second_out", out, x.o);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply.
        mode = 3'd0; in_A = 32'hDEAD_BEEF; in_B = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("abort_no_result", seen, 0);
        do_op(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r);
        chk("abort_next_err", r.e, 1);
        chk("abort_next_out", r.o, 0);
        chk("abort_next_lat", r.lat, 2);

        // Reset wins over a simultaneous request.
        mode = 3'd2; in_A = 32'hFFFF_FFFF; in_B = 32'hFFFF_FFFF; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_prio_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("rst_prio_still_idle", in_ready, 1);
        chk("rst_prio_no_valid", out_valid, 0);

        // Narrow instance.
        do_op8(3'd0, 8'hFF, 8'hFF, o8, lat8);
        chk("w8_mul_out", o8, 16'hFE01);
        chk("w8_mul_lat", lat8, 9);
        do_op8(3'd1, 8'hFF, 8'h10, o8, lat8);
        chk("w8_div_out", o8, 16'h0F0F);
        chk("w8_div_lat", lat8, 9);
        for (int i = 0; i < 12; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom_range(1, 255));
            if (i % 2 == 0) e8 = 16'(ra8) * 16'(rb8);
            else            e8 = {ra8 % rb8, ra8 / rb8};
            do_op8(3'(i % 2), ra8, rb8, o8, lat8);
            chk($sformatf("w8_rnd%0d_out", i), o8, e8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
